// File: rtl/spi_sram_target.sv
// spi_sram_target: SPI mode-0 SRAM-emulation responder (WRITE 0x02, READ 0x03).
// Define SPI_SRAM_TARGET_RDSR_EN to add the read-mode-register command 0x05.
module spi_sram_target #(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam int CW = $clog2(ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_RDSR,
    S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES:0]   warm;
  logic                   sclk_q;
  logic                   cs_q;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic ready;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [7:0]        shreg;
  logic [ADDR_W-1:0] addr;
  logic              is_read;
  logic [7:0]        tx;
  logic              rd_valid;

  logic [7:0]        byte_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [ADDR_W-1:0] addr_inc;
  logic              cnt_byte;
  logic              cnt_addr;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edges are ignored until the chains hold real pin levels, so a cs_n
  // already low at reset release is not mistaken for a new frame.
  assign ready     = warm[SYNC_STAGES];
  assign sclk_rise = ready & sclk_s & ~sclk_q;
  assign sclk_fall = ready & ~sclk_s & sclk_q;
  assign cs_fall   = ready & ~cs_s & cs_q;
  assign cs_rise   = ready & cs_s & ~cs_q;

  assign byte_nx  = {shreg[6:0], mosi_s};
  assign addr_nx  = {addr[ADDR_W-2:0], mosi_s};
  assign addr_inc = addr + ADDR_W'(1);
  assign cnt_byte = (cnt == CW'(7));
  assign cnt_addr = (cnt == CW'(ADDR_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      warm      <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      addr      <= '0;
      is_read   <= 1'b0;
      tx        <= '0;
      rd_valid  <= 1'b0;
      spi_miso  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      cmd_err  <= 1'b0;
      busy     <= ~cs_s;
      rd_valid <= mem_re;
      if (cs_rise) begin
        state    <= S_IDLE;
        spi_miso <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            spi_miso <= 1'b0;
            if (cs_fall) begin
              state <= S_CMD;
              cnt   <= '0;
            end
          end
          S_CMD: if (sclk_rise) begin
            shreg <= byte_nx;
            cnt   <= cnt + CW'(1);
            if (cnt_byte) begin
              cnt <= '0;
              unique case (1'b1)
                byte_nx == 8'h02,
                byte_nx == 8'h03: begin
                  state   <= S_ADDR;
                  is_read <= byte_nx[0];
                end
`ifdef SPI_SRAM_TARGET_RDSR_EN
                byte_nx == 8'h05: begin
                  state <= S_RDSR;
                  tx    <= 8'h40;
                end
`endif
                default: begin
                  state   <= S_IGNORE;
                  cmd_err <= 1'b1;
                end
              endcase
            end
          end
          S_ADDR: if (sclk_rise) begin
            addr <= addr_nx;
            cnt  <= cnt + CW'(1);
            if (cnt_addr) begin
              cnt <= '0;
              if (is_read) begin
                state    <= S_RDATA;
                mem_re   <= 1'b1;
                mem_addr <= addr_nx;
              end else begin
                state <= S_WDATA;
              end
            end
          end
          S_WDATA: if (sclk_rise) begin
            shreg <= byte_nx;
            cnt   <= cnt + CW'(1);
            if (cnt_byte) begin
              cnt       <= '0;
              mem_we    <= 1'b1;
              mem_addr  <= addr;
              mem_wdata <= byte_nx;
              addr      <= addr_inc;
            end
          end
          S_RDATA: begin
            // Read data lands two cycles after the strobe, well before
            // the next detected falling edge.
            if (rd_valid) begin
              tx <= mem_rdata;
            end else if (sclk_fall) begin
              spi_miso <= tx[7];
              tx       <= {tx[6:0], 1'b0};
            end
            if (sclk_rise) begin
              cnt <= cnt + CW'(1);
              if (cnt_byte) begin
                cnt      <= '0;
                addr     <= addr_inc;
                mem_addr <= addr_inc;
                mem_re   <= 1'b1;
              end
            end
          end
          S_RDSR: if (sclk_fall) begin
            spi_miso <= tx[7];
            tx       <= {tx[6:0], tx[7]};
          end
          S_IGNORE: spi_miso <= 1'b0;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_sram_target.sv
// tb_spi_sram_target: table-driven directed frames plus randomized
// frames checked against a byte-array reference memory.
module tb_spi_sram_target;

  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  logic        cmd_err;

  always #5 clk = ~clk;

  spi_sram_target #(
    .ADDR_W(16),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi_clk(spi_clk),
    .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .busy(busy),
    .cmd_err(cmd_err)
  );

  logic [7:0]  mem [65536];
  logic [7:0]  ref_mem [65536];
  logic [23:0] we_q[$];
  logic [15:0] re_q[$];
  int          err_cnt = 0;
  int          both_cnt = 0;
  int          miso_bad = 0;
  bit          rd_frame = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          we_b, re_b, err_b;
  logic        busy_mid;

  // Backing memory: read data valid on the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_we) we_q.push_back({mem_addr, mem_wdata});
    if (mem_re) re_q.push_back(mem_addr);
    if (cmd_err) err_cnt++;
    if (mem_we && mem_re) both_cnt++;
    if (spi_miso && !rd_frame) miso_bad++;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic spi_bits(input logic [31:0] v, input int n,
                          output logic [31:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = v[i];
      repeat (H) @(negedge clk);
      r = {r[30:0], spi_miso};
      spi_clk = 1'b1;
      repeat (H) @(negedge clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] a,
                           input bit has_addr, input int nb,
                           input logic [31:0] wd, input int xb,
                           output logic [31:0] rx);
    logic [31:0] r;
    rx = '0;
    we_b = we_q.size();
    re_b = re_q.size();
    err_b = err_cnt;
    rd_frame = (cmd == 8'h03 || cmd == 8'h05);
    spi_cs_n = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits({24'h0, cmd}, 8, r);
    if (has_addr) spi_bits({16'h0, a}, 16, r);
    for (int i = 0; i < nb; i++) begin
      spi_bits({24'h0, wd[8*(3-i) +: 8]}, 8, r);
      rx[8*(3-i) +: 8] = r[7:0];
    end
    if (xb > 0) spi_bits(32'hA, xb, r);
    repeat (H) @(negedge clk);
    busy_mid = busy;
    spi_cs_n = 1'b1;
    repeat (3 * H) @(negedge clk);
    rd_frame = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    bit          has_addr;
    int          nb;
    logic [31:0] wd;
    int          xb;
    int          e_err;
    int          e_nwe;
    logic [23:0] e_we0;
    logic [23:0] e_we1;
    int          e_nre;
    logic [15:0] e_re0;
    logic [15:0] e_re1;
    logic [15:0] e_rx;
  } vec_t;

  vec_t        tv [8];
  logic [31:0] rx;
  logic [31:0] r;
  logic [15:0] a;
  logic [15:0] ai;
  logic [31:0] wd;
  logic [23:0] ew;
  int          nb;
  bit          rd;
  logic [15:0] pool [4];

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[16'h00FF] = 8'h3C;
    mem[16'h0100] = 8'hC3;
    ref_mem[16'h00FF] = 8'h3C;
    ref_mem[16'h0100] = 8'hC3;

    tv[0] = '{8'h02, 16'h1234, 1'b1, 1, 32'hA500_0000, 0,
              0, 1, 24'h1234A5, 24'h0, 0, 16'h0, 16'h0, 16'h0000};
    tv[1] = '{8'h03, 16'h00FF, 1'b1, 2, 32'h0, 0,
              0, 0, 24'h0, 24'h0, 3, 16'h00FF, 16'h0100, 16'h3CC3};
    tv[2] = '{8'h02, 16'hFFFF, 1'b1, 2, 32'h1122_0000, 0,
              0, 2, 24'hFFFF11, 24'h000022, 0, 16'h0, 16'h0, 16'h0000};
    tv[3] = '{8'h02, 16'h0010, 1'b1, 1, 32'h5500_0000, 4,
              0, 1, 24'h001055, 24'h0, 0, 16'h0, 16'h0, 16'h0000};
    tv[4] = '{8'h03, 16'h0010, 1'b1, 1, 32'h0, 0,
              0, 0, 24'h0, 24'h0, 2, 16'h0010, 16'h0011, 16'h5500};
    tv[5] = '{8'h9F, 16'h0, 1'b0, 1, 32'h0, 0,
              1, 0, 24'h0, 24'h0, 0, 16'h0, 16'h0, 16'h0000};
`ifdef SPI_SRAM_TARGET_RDSR_EN
    tv[6] = '{8'h05, 16'h0, 1'b0, 2, 32'h0, 0,
              0, 0, 24'h0, 24'h0, 0, 16'h0, 16'h0, 16'h4040};
`else
    tv[6] = '{8'h05, 16'h0, 1'b0, 2, 32'h0, 0,
              1, 0, 24'h0, 24'h0, 0, 16'h0, 16'h0, 16'h0000};
`endif
    tv[7] = '{8'h03, 16'hFFFF, 1'b1, 2, 32'h0, 0,
              0, 0, 24'h0, 24'h0, 3, 16'hFFFF, 16'h0000, 16'h1122};

    repeat (3) @(negedge clk);
    check("reset_outs",
          {3'b0, spi_miso, mem_we, mem_re, cmd_err, busy, mem_wdata, mem_addr},
          32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      run_frame(tv[v].cmd, tv[v].addr, tv[v].has_addr, tv[v].nb,
                tv[v].wd, tv[v].xb, rx);
      check($sformatf("v%0d cmd_err", v), err_cnt - err_b, tv[v].e_err);
      check($sformatf("v%0d n_we", v), we_q.size() - we_b, tv[v].e_nwe);
      for (int i = 0; i < tv[v].e_nwe && we_b + i < we_q.size(); i++)
        check($sformatf("v%0d we%0d", v, i), {8'h0, we_q[we_b+i]},
              {8'h0, (i == 0) ? tv[v].e_we0 : tv[v].e_we1});
      check($sformatf("v%0d n_re", v), re_q.size() - re_b, tv[v].e_nre);
      for (int i = 0; i < tv[v].e_nre && i < 2 && re_b + i < re_q.size(); i++)
        check($sformatf("v%0d re%0d", v, i), {16'h0, re_q[re_b+i]},
              {16'h0, (i == 0) ? tv[v].e_re0 : tv[v].e_re1});
      check($sformatf("v%0d miso", v), {16'h0, rx[31:16]}, {16'h0, tv[v].e_rx});
      for (int i = 0; i < tv[v].e_nwe && i < 2; i++) begin
        ew = (i == 0) ? tv[v].e_we0 : tv[v].e_we1;
        ref_mem[ew[23:8]] = ew[7:0];
      end
      if (v == 0) begin
        check("busy_mid_frame", {31'h0, busy_mid}, 32'h1);
        check("busy_after_frame", {31'h0, busy}, 32'h0);
      end
    end

    pool[0] = 16'h0000;
    pool[1] = 16'h00F0;
    pool[2] = 16'h8000;
    pool[3] = 16'hFFFD;
    for (int k = 0; k < 24; k++) begin
      rd = 1'($urandom_range(0, 1));
      a = pool[$urandom_range(0, 3)] + 16'($urandom_range(0, 3));
      nb = $urandom_range(1, 4);
      wd = $urandom;
      run_frame(rd ? 8'h03 : 8'h02, a, 1'b1, nb, wd, 0, rx);
      if (!rd) begin
        check($sformatf("r%0d n_we", k), we_q.size() - we_b, nb);
        for (int i = 0; i < nb && we_b + i < we_q.size(); i++) begin
          ai = a + 16'(i);
          check($sformatf("r%0d we%0d", k, i), {8'h0, we_q[we_b+i]},
                {8'h0, ai, wd[8*(3-i) +: 8]});
        end
        for (int i = 0; i < nb; i++) begin
          ai = a + 16'(i);
          ref_mem[ai] = wd[8*(3-i) +: 8];
        end
      end else begin
        check($sformatf("r%0d n_re", k), re_q.size() - re_b, nb + 1);
        for (int i = 0; i < nb; i++) begin
          ai = a + 16'(i);
          check($sformatf("r%0d rd%0d", k, i), {24'h0, rx[8*(3-i) +: 8]},
                {24'h0, ref_mem[ai]});
          if (re_b + i < re_q.size())
            check($sformatf("r%0d re%0d", k, i), {16'h0, re_q[re_b+i]},
                  {16'h0, ai});
        end
      end
    end

    // Reset during the address phase of a READ, cs_n held low across release.
    re_b = re_q.size();
    err_b = err_cnt;
    spi_cs_n = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(32'h03, 8, r);
    spi_bits(32'h00, 8, r);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_outs",
          {3'b0, spi_miso, mem_we, mem_re, cmd_err, busy, mem_wdata, mem_addr},
          32'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    spi_bits(32'h9F, 8, r);
    spi_bits(32'hFF, 8, r);
    check("rst_no_stale_decode", err_cnt - err_b, 0);
    check("rst_no_re", re_q.size() - re_b, 0);
    check("rst_busy_cs_low", {31'h0, busy}, 32'h1);
    spi_cs_n = 1'b1;
    repeat (3 * H) @(negedge clk);
    run_frame(8'h03, 16'h00FF, 1'b1, 1, 32'h0, 0, rx);
    check("post_rst_read", {24'h0, rx[31:24]}, 32'h3C);
    check("post_rst_n_re", re_q.size() - re_b, 2);
    if (re_q.size() > re_b)
      check("post_rst_re0", {16'h0, re_q[re_b]}, 32'h00FF);

    check("we_re_overlap", both_cnt, 0);
    check("miso_outside_read", miso_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
